// File: rtl/sram_arbiter_pkg.sv
// Shared types, constants and the byte-merge helper for the SRAM arbiter.
package sram_arbiter_pkg;

   localparam int DATA_W = 32;

   // Controller states, kept as plain constants so the encoding is explicit.
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_RD       = 3'd1;
   localparam state_t ST_WR       = 3'd2;
   localparam state_t ST_WR_END   = 3'd3;
   localparam state_t ST_RMW_RD   = 3'd4;
   localparam state_t ST_RMW_TURN = 3'd5;
   localparam state_t ST_DONE     = 3'd6;

   // Identity of the bus port that owns the current access.
   typedef enum logic {
      PORT_IF = 1'b0,
      PORT_DM = 1'b1
   } port_t;

   // Replace the bytes of old_word selected by sel with the bytes of new_word.
   function automatic logic [DATA_W-1:0] byte_merge(
      input logic [DATA_W-1:0] old_word,
      input logic [DATA_W-1:0] new_word,
      input logic [3:0]        sel
   );
      logic [DATA_W-1:0] merged;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates one asynchronous 32-bit SRAM between the fetch and data ports,
// generating wait-stated strobes and read-modify-write for partial stores.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [31:0]       if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [3:0]        dm_sel,
   input  logic [31:0]       dm_wdata,
   output logic              dm_ack,
   output logic [31:0]       dm_rdata,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_data_o,
   output logic              sram_data_t,
   input  logic [31:0]       sram_data_i,
   output logic              sram_ce,
   output logic              sram_oe,
   output logic              sram_we
);

   localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt;
   logic               cnt_done;
   logic               take;
   logic               grant_dm;
   port_t              port_q, port_n, last_grant;
   logic [3:0]         sel_q;
   logic [DATA_W-1:0]  wdata_q;

   assign cnt_done = (cnt == '0);
   assign take     = (state == ST_IDLE) && (if_req || dm_req);

   // Next-state decode and round-robin choice between the two ports.
   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_n  = state;
      grant_dm = dm_req && (!if_req || last_grant == PORT_IF);
      port_n   = port_q;
      if (take) port_n = grant_dm ? PORT_DM : PORT_IF;
      case (state)
         ST_IDLE: begin
            if (grant_dm) begin
               if (!dm_we)               state_n = ST_RD;
               else if (dm_sel == 4'hF)  state_n = ST_WR;
               else if (dm_sel == 4'h0)  state_n = ST_DONE;
               else                      state_n = ST_RMW_RD;
            end else if (if_req) begin
               state_n = ST_RD;
            end
         end
         ST_RD:       if (cnt_done) state_n = ST_DONE;
         ST_RMW_RD:   if (cnt_done) state_n = ST_RMW_TURN;
         ST_RMW_TURN:               state_n = ST_WR;
         ST_WR:       if (cnt_done) state_n = ST_WR_END;
         ST_WR_END:                 state_n = ST_DONE;
         ST_DONE:                   state_n = ST_IDLE;
         default:                   state_n = ST_IDLE;
      endcase
   end

   // State register and wait counter; the counter reloads whenever the state changes.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         if (state_n != state) cnt <= CNT_W'(WAIT_CYCLES - 1);
         else if (!cnt_done)   cnt <= cnt - CNT_W'(1);
      end
   end

   // Latch the winning request and build the word to write.
   always_ff @(posedge clk) begin
      if (rst) begin
         port_q      <= PORT_IF;
         last_grant  <= PORT_IF;
         sel_q       <= '0;
         wdata_q     <= '0;
         sram_addr   <= '0;
         sram_data_o <= '0;
      end else begin
         if (take) begin
            port_q      <= port_n;
            last_grant  <= port_n;
            sram_addr   <= grant_dm ? dm_addr : if_addr;
            sel_q       <= dm_sel;
            wdata_q     <= dm_wdata;
            sram_data_o <= dm_wdata;
         end
         if (state == ST_RMW_RD && cnt_done)
            sram_data_o <= byte_merge(sram_data_i, wdata_q, sel_q);
      end
   end

   // Registered pad strobes, acks and read data, all derived from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         sram_ce     <= 1'b1;
         sram_oe     <= 1'b1;
         sram_we     <= 1'b1;
         sram_data_t <= 1'b0;
         if_ack      <= 1'b0;
         dm_ack      <= 1'b0;
         if_rdata    <= '0;
         dm_rdata    <= '0;
      end else begin
         sram_ce     <= !(state_n inside {ST_RD, ST_RMW_RD, ST_RMW_TURN, ST_WR, ST_WR_END});
         sram_oe     <= !(state_n inside {ST_RD, ST_RMW_RD});
         sram_we     <= (state_n != ST_WR);
         sram_data_t <= (state_n inside {ST_WR, ST_WR_END});
         if_ack      <= (state_n == ST_DONE) && (port_n == PORT_IF);
         dm_ack      <= (state_n == ST_DONE) && (port_n == PORT_DM);
         if (state == ST_RD && cnt_done) begin
            if (port_q == PORT_DM) dm_rdata <= sram_data_i;
            else                   if_rdata <= sram_data_i;
         end
      end
   end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares one asynchronous 32-bit SRAM bank (base or ext RAM) between the CPU instruction-fetch port and the data-memory port inside the SoC. Issues SRAM cycles with a programmable number of wait states. Performs read-modify-write for partial-word stores, since the SRAM has no byte enables. Round-robin grant on conflict; it sits between the CPU bus ports and the top-level SRAM pins.

## Interface
Parameters:
- WAIT_CYCLES, 2, cycles each oe/we strobe is held low (≥1)
- ADDR_W, 20, SRAM word-address width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch word address
- if_ack  out  1  one-cycle completion pulse
- if_rdata  out  32  fetch data, valid with if_ack
- dm_req  in  1  data request, held until dm_ack
- dm_we  in  1  1 = write
- dm_addr  in  ADDR_W  data word address
- dm_sel  in  4  byte enables, bit i = bits 8i+7:8i
- dm_wdata  in  32  write data
- dm_ack  out  1  one-cycle completion pulse
- dm_rdata  out  32  read data, valid with dm_ack
- sram_addr  out  ADDR_W  SRAM address
- sram_data_o  out  32  data driven to SRAM
- sram_data_t  out  1  1 = drive sram_data_o onto pad (tristate at top)
- sram_data_i  in  32  data from pad
- sram_ce  out  1  chip enable, active low
- sram_oe  out  1  output enable, active low
- sram_we  out  1  write enable, active low

## Operation
- Clock and reset: one clock; reset is synchronous and active-high, ports named clk and rst.
- FSM states: IDLE, RD, WR, WR_END, RMW_RD, RMW_TURN, DONE.
- Requests are sampled only in IDLE.
- Arbitration:
  - One requester active: that requester is granted.
  - Both active: the requester not granted last time wins.
  - last_grant resets to IF, so DM wins the first tie.
- On grant, latch port id, address, we, sel and wdata; next state depends on the request:
  - Read → RD.
  - Write with sel=4'hF → WR.
  - Write with sel=0 → DONE; no SRAM activity.
  - Other writes → RMW_RD.
- RD / RMW_RD: ce=0, oe=0, sram_data_t=0 for WAIT_CYCLES cycles. sram_data_i is captured on the last cycle.
  - RD: captured word goes to the granted port's rdata register; → DONE.
  - RMW_RD: captured word is merged with wdata per sel (selected bytes from wdata); → RMW_TURN.
- RMW_TURN: one cycle with ce=0, oe=1, we=1, no drive (bus turnaround); → WR with the merged word.
- WR: ce=0, sram_data_t=1, we=0 for WAIT_CYCLES cycles; → WR_END.
- WR_END: one cycle with we=1, ce=0, data still driven (hold); → DONE.
- DONE: ack=1 for the granted port only; all SRAM controls high, no drive; → IDLE.
- rdata registers update only on RD completion. They are unchanged by writes and RMW.
- A request still held after ack is treated as a new request in the following IDLE cycle.
- sram_addr holds the latched address from grant through DONE.

## Timing
- All outputs are registered.
- Reset values:
  - sram_ce, sram_oe, sram_we = 1; sram_data_t = 0.
  - sram_addr, sram_data_o = 0.
  - if_ack, dm_ack = 0; if_rdata, dm_rdata = 0.
  - State = IDLE, last_grant = IF.
- Latency, measured from the IDLE cycle that sees req (cycle 0) to the ack cycle, with W = WAIT_CYCLES:
  - Read: W+1.
  - Full write: W+2.
  - RMW write: 2W+3.
  - sel=0 write: 1.
- Throughput: back-to-back requests lose one IDLE cycle between accesses.
- we and oe are never low together; data is never driven while oe is low.
- Reset asserted mid-access: the next edge forces IDLE and deasserts all controls and drive. No ack is issued for the aborted access.
- The wait counter is sized to hold WAIT_CYCLES and reloads on every state entry.

## Structure
- Package sram_arbiter_pkg holds:
  - the state enum and the port-id enum (IF/DM);
  - DATA_W=32;
  - a byte_merge(old, new, sel) function.
- Single module; no sub-module needed. Top-level pad tristate stays outside, driven from sram_data_t.

## Test plan
- Read, W=2: dm_req, addr 0x00010, SRAM model word 0xDEADBEEF → dm_ack exactly 3 cycles after grant; dm_rdata = 0xDEADBEEF; oe low for 2 cycles; we stays high.
- Full write: dm_we=1, sel=F, wdata 0x12345678 to 0x00020 → we low 2 cycles, hold cycle with data driven, ack at cycle 4; model reads back 0x12345678.
- RMW: memory 0xAABBCCDD, sel=4'b0101, wdata 0x11223344 → final memory 0xAA22CC44; ack at cycle 7; exactly one turnaround cycle with no drive and oe high.
- Contention: if_req and dm_req held continuously → grants alternate DM, IF, DM, IF; no ack to the wrong port; no starvation.
- sel=0 write → dm_ack next cycle; ce stays high throughout.
- Reset during WR → next cycle ce/oe/we = 1, sram_data_t = 0, no dm_ack; a fresh read afterwards completes normally.
